// File: rtl/rock_field.sv
// rock_field: pool of NUM_ROCKS wrapping asteroid slots with spawn/hit control and a cross-sprite pixel layer.
// Optional ROCK_SPLIT_EN: a first hit shrinks a large rock and clones a small fragment into a free slot.
module rock_field #(
   parameter int NUM_ROCKS = 4,
   parameter int IDX_W     = 2,
   parameter int COORD_W   = 10,
   parameter int SPEED_W   = 2,
   parameter int SCREEN_W  = 640,
   parameter int SCREEN_H  = 480,
   parameter int HALF_L    = 12,
   parameter int HALF_S    = 10
) (
   input  logic                 clk60hz,
   input  logic                 reset_n,
   input  logic [COORD_W-1:0]   px,
   input  logic [COORD_W-1:0]   py,
   input  logic                 spawn_valid,
   output logic                 spawn_ready,
   input  logic [COORD_W-1:0]   spawn_x,
   input  logic [COORD_W-1:0]   spawn_y,
   input  logic [SPEED_W:0]     spawn_dx,
   input  logic [SPEED_W:0]     spawn_dy,
   input  logic                 hit_valid,
   input  logic [IDX_W-1:0]     hit_idx,
   input  logic                 clear_all,
   output logic                 pixel,
   output logic [IDX_W-1:0]     pixel_idx,
   output logic [NUM_ROCKS-1:0] active_mask,
   output logic [IDX_W:0]       active_count
);

   localparam int CW = COORD_W + 1;

   logic [COORD_W-1:0]   posX   [NUM_ROCKS];
   logic [COORD_W-1:0]   posY   [NUM_ROCKS];
   logic [SPEED_W:0]     velX   [NUM_ROCKS];
   logic [SPEED_W:0]     velY   [NUM_ROCKS];
   logic [COORD_W-1:0]   movedX [NUM_ROCKS];
   logic [COORD_W-1:0]   movedY [NUM_ROCKS];
   logic [NUM_ROCKS-1:0] activeNext;
   logic [IDX_W:0]       countNext;
   logic                 freeHit;
   logic [IDX_W-1:0]     freeIdx;
   logic                 spawnFire;
   logic                 hitOk;
`ifdef ROCK_SPLIT_EN
   logic [NUM_ROCKS-1:0] isSmall;
   logic                 cloneHit;
   logic [IDX_W-1:0]     cloneIdx;
`endif

   // Sign-magnitude step with wrap, evaluated one bit wider than a coordinate.
   function automatic logic [COORD_W-1:0] stepAxis(input logic [COORD_W-1:0] pos,
                                                   input logic [SPEED_W:0] vel,
                                                   input int unsigned limit);
      logic [CW-1:0] p, m, l, r;
      p = {1'b0, pos};
      m = CW'(vel[SPEED_W-1:0]);
      l = CW'(limit);
      if (vel[SPEED_W]) begin
         r = (p < m) ? p + l - m : p - m;
      end else begin
         r = p + m;
         if (r >= l) r = r - l;
      end
      return r[COORD_W-1:0];
   endfunction

   assign spawn_ready = reset_n && (active_mask != '1) && !clear_all;
   assign spawnFire   = spawn_valid && spawn_ready;
   assign hitOk       = hit_valid && (int'(hit_idx) < NUM_ROCKS) && active_mask[hit_idx];

   always_comb begin
      freeHit = 1'b0;
      freeIdx = '0;
      for (int unsigned i = 0; i < NUM_ROCKS; i++) begin
         if (!active_mask[i] && !freeHit) begin
            freeHit = 1'b1;
            freeIdx = IDX_W'(i);
         end
      end
   end

`ifdef ROCK_SPLIT_EN
   always_comb begin
      cloneHit = 1'b0;
      cloneIdx = '0;
      for (int unsigned i = 0; i < NUM_ROCKS; i++) begin
         if (!active_mask[i] && !cloneHit && !(spawnFire && IDX_W'(i) == freeIdx)) begin
            cloneHit = 1'b1;
            cloneIdx = IDX_W'(i);
         end
      end
   end
`endif

   always_comb begin
      for (int unsigned i = 0; i < NUM_ROCKS; i++) begin
         movedX[i] = stepAxis(posX[i], velX[i], SCREEN_W);
         movedY[i] = stepAxis(posY[i], velY[i], SCREEN_H);
      end
   end

   always_comb begin
      activeNext = active_mask;
      if (clear_all) begin
         activeNext = '0;
      end else begin
`ifdef ROCK_SPLIT_EN
         if (hitOk && !isSmall[hit_idx]) begin
            if (cloneHit) activeNext[cloneIdx] = 1'b1;
         end else if (hitOk) begin
            activeNext[hit_idx] = 1'b0;
         end
`else
         if (hitOk) activeNext[hit_idx] = 1'b0;
`endif
         if (spawnFire) activeNext[freeIdx] = 1'b1;
      end
   end

   // Count is taken from the next mask so it lands in the same cycle as active_mask.
   always_comb begin
      countNext = '0;
      for (int unsigned i = 0; i < NUM_ROCKS; i++) begin
         countNext = countNext + (IDX_W+1)'(activeNext[i]);
      end
   end

   always_ff @(posedge clk60hz or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < NUM_ROCKS; i++) begin
            posX[i] <= '0;
            posY[i] <= '0;
            velX[i] <= '0;
            velY[i] <= '0;
         end
         active_mask  <= '0;
         active_count <= '0;
`ifdef ROCK_SPLIT_EN
         isSmall      <= '0;
`endif
      end else begin
         active_mask  <= activeNext;
         active_count <= countNext;
         for (int unsigned i = 0; i < NUM_ROCKS; i++) begin
            if (active_mask[i]) begin
               posX[i] <= movedX[i];
               posY[i] <= movedY[i];
            end
         end
         if (!clear_all) begin
`ifdef ROCK_SPLIT_EN
            if (hitOk && !isSmall[hit_idx]) begin
               isSmall[hit_idx]       <= 1'b1;
               velX[hit_idx][SPEED_W] <= ~velX[hit_idx][SPEED_W];
               if (cloneHit) begin
                  isSmall[cloneIdx] <= 1'b1;
                  posX[cloneIdx]    <= movedX[hit_idx];
                  posY[cloneIdx]    <= movedY[hit_idx];
                  velX[cloneIdx]    <= velX[hit_idx];
                  velY[cloneIdx]    <= {~velY[hit_idx][SPEED_W], velY[hit_idx][SPEED_W-1:0]};
               end
            end
`endif
            if (spawnFire) begin
               posX[freeIdx] <= spawn_x;
               posY[freeIdx] <= spawn_y;
               velX[freeIdx] <= spawn_dx;
               velY[freeIdx] <= spawn_dy;
`ifdef ROCK_SPLIT_EN
               isSmall[freeIdx] <= 1'b0;
`endif
            end
         end
      end
   end

   always_comb begin
      logic signed [CW-1:0] dX, dY;
      logic [CW-1:0] aX, aY, extL, extS;
      pixel     = 1'b0;
      pixel_idx = '0;
      dX = '0; dY = '0; aX = '0; aY = '0; extL = '0; extS = '0;
      for (int unsigned i = 0; i < NUM_ROCKS; i++) begin
         dX   = $signed({1'b0, px}) - $signed({1'b0, posX[i]});
         dY   = $signed({1'b0, py}) - $signed({1'b0, posY[i]});
         aX   = dX[CW-1] ? $unsigned(-dX) : $unsigned(dX);
         aY   = dY[CW-1] ? $unsigned(-dY) : $unsigned(dY);
         extL = CW'(HALF_L);
         extS = CW'(HALF_S);
`ifdef ROCK_SPLIT_EN
         if (isSmall[i]) begin
            extL = CW'(HALF_L / 2);
            extS = CW'(HALF_S / 2);
         end
`endif
         if (active_mask[i] && !pixel &&
             ((aX < extL && aY < extS) || (aX < extS && aY < extL))) begin
            pixel     = 1'b1;
            pixel_idx = IDX_W'(i);
         end
      end
   end

endmodule

// File: tb/tb_rock_field.sv
// Self-checking bench for rock_field: directed scenarios plus randomized traffic against a slot-pool model.
// Build with +define+ROCK_SPLIT_EN to exercise the split feature in both DUT and model.
module tb_rock_field;

   localparam int N = 4, IW = 2, CWD = 10, SW = 2, W = 640, H = 480, HL = 12, HS = 10;

   logic            clk60hz = 1'b0;
   logic            reset_n = 1'b0;
   logic [CWD-1:0]  px = '0, py = '0;
   logic            spawn_valid = 1'b0;
   logic            spawn_ready;
   logic [CWD-1:0]  spawn_x = '0, spawn_y = '0;
   logic [SW:0]     spawn_dx = '0, spawn_dy = '0;
   logic            hit_valid = 1'b0;
   logic [IW-1:0]   hit_idx = '0;
   logic            clear_all = 1'b0;
   logic            pixel;
   logic [IW-1:0]   pixel_idx;
   logic [N-1:0]    active_mask;
   logic [IW:0]     active_count;

   always #5 clk60hz = ~clk60hz;

   rock_field #(.NUM_ROCKS(N), .IDX_W(IW), .COORD_W(CWD), .SPEED_W(SW),
                .SCREEN_W(W), .SCREEN_H(H), .HALF_L(HL), .HALF_S(HS)) dut (
      .clk60hz(clk60hz), .reset_n(reset_n), .px(px), .py(py),
      .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
      .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_dx(spawn_dx), .spawn_dy(spawn_dy),
      .hit_valid(hit_valid), .hit_idx(hit_idx), .clear_all(clear_all),
      .pixel(pixel), .pixel_idx(pixel_idx), .active_mask(active_mask), .active_count(active_count));

   // Reference model: plain integers per slot.
   int mX[N], mY[N], mDx[N], mDy[N];
   bit mAct[N], mSmall[N];
   int checks = 0, fails = 0;

   function automatic int sm(input logic [SW:0] v);
      int mag;
      mag = int'(v[SW-1:0]);
      return v[SW] ? -mag : mag;
   endfunction

   function automatic int wrapAdd(input int p, input int d, input int lim);
      return ((p + d) % lim + lim) % lim;
   endfunction

   function automatic logic [N-1:0] modelMask();
      logic [N-1:0] m;
      m = '0;
      for (int i = 0; i < N; i++) m[i] = mAct[i];
      return m;
   endfunction

   function automatic int modelCount();
      int c;
      c = 0;
      for (int i = 0; i < N; i++) c += int'(mAct[i]);
      return c;
   endfunction

   function automatic void modelPix(input int x, input int y, output bit hit, output int idx);
      int ax, ay, el, es;
      hit = 0; idx = 0;
      for (int i = 0; i < N; i++) begin
         ax = (x > mX[i]) ? x - mX[i] : mX[i] - x;
         ay = (y > mY[i]) ? y - mY[i] : mY[i] - y;
         el = mSmall[i] ? HL / 2 : HL;
         es = mSmall[i] ? HS / 2 : HS;
         if (mAct[i] && !hit && ((ax < el && ay < es) || (ax < es && ay < el))) begin
            hit = 1; idx = i;
         end
      end
   endfunction

   task automatic modelReset();
      for (int i = 0; i < N; i++) begin
         mX[i] = 0; mY[i] = 0; mDx[i] = 0; mDy[i] = 0; mAct[i] = 0; mSmall[i] = 0;
      end
   endtask

   // Advance the model by one frame from the current inputs, then let the DUT take the same edge.
   task automatic step();
      int fr, cl, h;
      bit fire, hitOk;
      fr = -1; cl = -1;
      fire = spawn_valid && !clear_all && (modelMask() != '1);
      for (int i = 0; i < N; i++) if (!mAct[i] && fr < 0) fr = i;
      for (int i = 0; i < N; i++) if (!mAct[i] && cl < 0 && !(fire && i == fr)) cl = i;
      h = int'(hit_idx);
      hitOk = hit_valid && (h < N) && mAct[h];
      for (int i = 0; i < N; i++) begin
         if (mAct[i]) begin
            mX[i] = wrapAdd(mX[i], mDx[i], W);
            mY[i] = wrapAdd(mY[i], mDy[i], H);
         end
      end
      if (clear_all) begin
         for (int i = 0; i < N; i++) mAct[i] = 0;
      end else begin
         if (hitOk) begin
`ifdef ROCK_SPLIT_EN
            if (!mSmall[h]) begin
               if (cl >= 0) begin
                  mAct[cl] = 1; mSmall[cl] = 1;
                  mX[cl] = mX[h]; mY[cl] = mY[h];
                  mDx[cl] = mDx[h]; mDy[cl] = -mDy[h];
               end
               mSmall[h] = 1;
               mDx[h] = -mDx[h];
            end else begin
               mAct[h] = 0;
            end
`else
            mAct[h] = 0;
`endif
         end
         if (fire) begin
            mAct[fr] = 1; mSmall[fr] = 0;
            mX[fr] = int'(spawn_x); mY[fr] = int'(spawn_y);
            mDx[fr] = sm(spawn_dx); mDy[fr] = sm(spawn_dy);
         end
      end
      @(posedge clk60hz);
      #1;
   endtask

   task automatic idle();
      spawn_valid = 0; hit_valid = 0; clear_all = 0;
   endtask

   task automatic setSpawn(input int x, input int y, input logic [SW:0] dx, input logic [SW:0] dy);
      spawn_x = CWD'(x); spawn_y = CWD'(y); spawn_dx = dx; spawn_dy = dy;
   endtask

   task automatic clearStep();
      idle(); clear_all = 1; step(); clear_all = 0;
   endtask

   task automatic test_reset();
      int rx, ry;
      #3;
      checks++; if (active_mask !== '0) begin fails++; $display("FAIL reset_mask: got %0h expected 0", active_mask); end
      checks++; if (spawn_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %0b expected 0", spawn_ready); end
      @(posedge clk60hz); #1;
      reset_n = 1; modelReset();
      #1;
      checks++; if (spawn_ready !== 1'b1) begin fails++; $display("FAIL release_ready: got %0b expected 1", spawn_ready); end
      spawn_valid = 1;
      for (int i = 0; i < 3; i++) begin
         setSpawn(100 + 150 * i, 100 + 40 * i, 3'b001, 3'b101);
         step();
      end
      idle(); step();
      checks++; if (active_mask !== 4'b0111) begin fails++; $display("FAIL pre_reset_mask: got %0h expected 7", active_mask); end
      rx = mX[0]; ry = mY[0];
      reset_n = 0; #2;
      modelReset();
      px = CWD'(rx); py = CWD'(ry); #1;
      checks++; if (active_mask !== '0) begin fails++; $display("FAIL midreset_mask: got %0h expected 0", active_mask); end
      checks++; if (active_count !== '0) begin fails++; $display("FAIL midreset_count: got %0d expected 0", active_count); end
      checks++; if (pixel !== 1'b0) begin fails++; $display("FAIL midreset_pixel: got %0b expected 0", pixel); end
      checks++; if (spawn_ready !== 1'b0) begin fails++; $display("FAIL midreset_ready: got %0b expected 0", spawn_ready); end
      reset_n = 1; #1;
      checks++; if (spawn_ready !== 1'b1) begin fails++; $display("FAIL postreset_ready: got %0b expected 1", spawn_ready); end
   endtask

   task automatic test_spawn_motion();
      bit eh; int ei;
      setSpawn(100, 50, 3'b010, 3'b101); spawn_valid = 1;
      step(); idle();
      checks++; if (active_mask !== 4'b0001) begin fails++; $display("FAIL spawn_mask: got %0h expected 1", active_mask); end
      checks++; if (active_count !== 3'd1) begin fails++; $display("FAIL spawn_count: got %0d expected 1", active_count); end
      repeat (3) step();
      px = 10'd110; py = 10'd47; #1;
      modelPix(110, 47, eh, ei);
      checks++; if (pixel !== 1'b1 || eh != 1) begin fails++; $display("FAIL motion_in: got %0b expected 1", pixel); end
      checks++; if (pixel_idx !== 2'd0) begin fails++; $display("FAIL motion_idx: got %0d expected 0", pixel_idx); end
      px = 10'd118; #1;
      checks++; if (pixel !== 1'b0) begin fails++; $display("FAIL motion_edge: got %0b expected 0", pixel); end
      px = 10'd106; py = 10'd38; #1;
      checks++; if (pixel !== 1'b1) begin fails++; $display("FAIL motion_vert: got %0b expected 1", pixel); end
   endtask

   task automatic test_wrap();
      clearStep();
      setSpawn(639, 0, 3'b001, 3'b110); spawn_valid = 1;
      step(); idle();
      px = 10'd639; py = 10'd0; #1;
      checks++; if (pixel !== 1'b1) begin fails++; $display("FAIL wrap_load: got %0b expected 1", pixel); end
      step();
      px = 10'd0; py = 10'd478; #1;
      checks++; if (pixel !== 1'b1) begin fails++; $display("FAIL wrap_new: got %0b expected 1", pixel); end
      px = 10'd639; py = 10'd0; #1;
      checks++; if (pixel !== 1'b0) begin fails++; $display("FAIL wrap_old: got %0b expected 0", pixel); end
      px = 10'd11; py = 10'd478; #1;
      checks++; if (pixel !== 1'b1) begin fails++; $display("FAIL wrap_reach: got %0b expected 1", pixel); end
   endtask

   task automatic test_fill();
      clearStep();
      spawn_valid = 1;
      for (int i = 0; i < N; i++) begin
         setSpawn(50 + 150 * i, 50, 3'b000, 3'b100);
         step();
      end
      checks++; if (spawn_ready !== 1'b0) begin fails++; $display("FAIL fill_ready: got %0b expected 0", spawn_ready); end
      checks++; if (active_mask !== 4'hf) begin fails++; $display("FAIL fill_mask: got %0h expected f", active_mask); end
      checks++; if (active_count !== 3'd4) begin fails++; $display("FAIL fill_count: got %0d expected 4", active_count); end
      setSpawn(300, 300, 3'b000, 3'b000);
      hit_valid = 1; hit_idx = 2'd2;
      step();
      checks++; if (active_mask !== 4'hb) begin fails++; $display("FAIL hitspawn_mask: got %0h expected b", active_mask); end
      checks++; if (active_count !== 3'd3) begin fails++; $display("FAIL hitspawn_count: got %0d expected 3", active_count); end
      hit_valid = 0;
      step(); idle();
      px = 10'd300; py = 10'd300; #1;
      checks++; if (active_mask !== 4'hf) begin fails++; $display("FAIL realloc_mask: got %0h expected f", active_mask); end
      checks++; if (pixel !== 1'b1 || pixel_idx !== 2'd2) begin fails++; $display("FAIL realloc_idx: got %0b/%0d expected 1/2", pixel, pixel_idx); end
   endtask

   task automatic test_hit_clear();
      clearStep();
      setSpawn(320, 240, 3'b000, 3'b000); spawn_valid = 1;
      step(); idle();
      hit_valid = 1; hit_idx = 2'd3;
      step(); idle();
      checks++; if (active_mask !== 4'b0001) begin fails++; $display("FAIL hit_inactive: got %0h expected 1", active_mask); end
      clear_all = 1; spawn_valid = 1; #1;
      checks++; if (spawn_ready !== 1'b0) begin fails++; $display("FAIL clear_ready: got %0b expected 0", spawn_ready); end
      step(); idle();
      px = 10'd320; py = 10'd240; #1;
      checks++; if (active_mask !== '0) begin fails++; $display("FAIL clear_mask: got %0h expected 0", active_mask); end
      checks++; if (active_count !== '0) begin fails++; $display("FAIL clear_count: got %0d expected 0", active_count); end
      checks++; if (pixel !== 1'b0) begin fails++; $display("FAIL clear_pixel: got %0b expected 0", pixel); end
   endtask

`ifdef ROCK_SPLIT_EN
   task automatic test_split();
      clearStep();
      setSpawn(300, 200, 3'b001, 3'b001); spawn_valid = 1;
      step(); idle();
      hit_valid = 1; hit_idx = 2'd0;
      step(); idle();
      checks++; if (active_mask !== 4'b0011) begin fails++; $display("FAIL split_mask: got %0h expected 3", active_mask); end
      checks++; if (active_count !== 3'd2) begin fails++; $display("FAIL split_count: got %0d expected 2", active_count); end
      px = 10'd308; py = 10'd201; #1;
      checks++; if (pixel !== 1'b0) begin fails++; $display("FAIL split_small: got %0b expected 0", pixel); end
      step();
      px = 10'd307; py = 10'd200; #1;
      checks++; if (pixel !== 1'b1 || pixel_idx !== 2'd1) begin fails++; $display("FAIL split_clone: got %0b/%0d expected 1/1", pixel, pixel_idx); end
      px = 10'd295; py = 10'd202; #1;
      checks++; if (pixel !== 1'b1 || pixel_idx !== 2'd0) begin fails++; $display("FAIL split_orig: got %0b/%0d expected 1/0", pixel, pixel_idx); end
      hit_valid = 1; hit_idx = 2'd0;
      step(); idle();
      checks++; if (active_mask !== 4'b0010) begin fails++; $display("FAIL split_free: got %0h expected 2", active_mask); end
   endtask
`endif

   task automatic test_random();
      bit eh; int ei, k, x, y;
      logic expReady;
      clearStep();
      for (int c = 0; c < 400; c++) begin
         spawn_valid = ($urandom_range(0, 1) == 1);
         hit_valid   = ($urandom_range(0, 9) < 4);
         hit_idx     = IW'($urandom_range(0, N - 1));
         clear_all   = ($urandom_range(0, 39) == 0);
         setSpawn(int'($urandom_range(0, W - 1)), int'($urandom_range(0, H - 1)),
                  SW'($urandom_range(0, 7)), SW'($urandom_range(0, 7)));
         #1;
         expReady = !clear_all && (modelMask() != '1);
         checks++; if (spawn_ready !== expReady) begin fails++; $display("FAIL rnd_ready c=%0d: got %0b expected %0b", c, spawn_ready, expReady); end
         step();
         checks++; if (active_mask !== modelMask()) begin fails++; $display("FAIL rnd_mask c=%0d: got %0h expected %0h", c, active_mask, modelMask()); end
         checks++; if (int'(active_count) != modelCount()) begin fails++; $display("FAIL rnd_count c=%0d: got %0d expected %0d", c, active_count, modelCount()); end
         k = int'($urandom_range(0, N - 1));
         x = mX[k] + int'($urandom_range(0, 28)) - 14;
         y = mY[k] + int'($urandom_range(0, 28)) - 14;
         if (x < 0) x = 0;
         if (y < 0) y = 0;
         px = CWD'(x); py = CWD'(y); #1;
         modelPix(x, y, eh, ei);
         checks++; if (pixel !== eh || int'(pixel_idx) != ei) begin fails++; $display("FAIL rnd_pixel c=%0d (%0d,%0d): got %0b/%0d expected %0b/%0d", c, x, y, pixel, pixel_idx, eh, ei); end
      end
      idle();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      modelReset();
      test_reset();
      test_spawn_motion();
      test_wrap();
      test_fill();
      test_hit_clear();
`ifdef ROCK_SPLIT_EN
      test_split();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
